// File: rtl/sd_reg_arbiter.sv
// sd_reg_arbiter
//   Shares the single-port SD register file (synchronous 1-cycle read)
//   between requester A (SPI link) and requester B (SD card engine).
//   Round-robin arbitration, optional lock for atomic sequences, and a
//   lock timeout so a stalled owner cannot starve the other side.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_x/we_x/lock_x/addr_x/wdata_x requester x transaction (x = a, b)
//   gnt_x                            1-cycle pulse: transaction issued
//   rvalid_x/rdata_x                 1-cycle read return; rdata_x holds
//   mem_addr/mem_we/mem_wdata        register file command (registered)
//   mem_rdata                        register file data, 1 cycle after addr
//   lock_owner                       00 none, 01 A, 10 B
//   timeout_err                      1-cycle pulse on forced lock release
module sd_reg_arbiter #(
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic              lock_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic              lock_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        lock_owner,
  output logic              timeout_err
);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  localparam int unsigned CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  logic             w_elig_a;
  logic             w_elig_b;
  logic             w_win_a;
  logic             w_win_b;
  logic             w_owner_acc;
  logic             w_timeout;

  logic             r_last_b;   // 1: B was granted last, so A wins a tie
  logic [CNT_W-1:0] r_cnt;      // cycles since the owner's last acceptance
  // Read delay line: stage 1 = address cycle, stage 2 = mem_rdata cycle
  logic             r_p1_v;
  logic             r_p1_b;
  logic             r_p2_v;
  logic             r_p2_b;

  always_comb begin
    w_elig_a    = req_a & ~gnt_a & ((lock_owner == OWN_NONE) | (lock_owner == OWN_A));
    w_elig_b    = req_b & ~gnt_b & ((lock_owner == OWN_NONE) | (lock_owner == OWN_B));
    w_win_a     = w_elig_a & (~w_elig_b | r_last_b);
    w_win_b     = w_elig_b & (~w_elig_a | ~r_last_b);
    w_owner_acc = ((lock_owner == OWN_A) & w_win_a) | ((lock_owner == OWN_B) & w_win_b);
    // Fires on the LOCK_TIMEOUT-th edge without an owner acceptance;
    // an owner acceptance on the same edge takes precedence.
    w_timeout   = (lock_owner != OWN_NONE) & ~w_owner_acc &
                  (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      rvalid_a    <= 1'b0;
      rvalid_b    <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      lock_owner  <= OWN_NONE;
      timeout_err <= 1'b0;
      r_last_b    <= 1'b1;
      r_cnt       <= '0;
      r_p1_v      <= 1'b0;
      r_p1_b      <= 1'b0;
      r_p2_v      <= 1'b0;
      r_p2_b      <= 1'b0;
    end else begin
      gnt_a       <= w_win_a;
      gnt_b       <= w_win_b;
      mem_we      <= 1'b0;
      timeout_err <= 1'b0;
      rvalid_a    <= 1'b0;
      rvalid_b    <= 1'b0;

      // A winner is always owner or unlocked, so release and
      // "no lock taken" both leave lock_owner at none.
      if (w_win_a) begin
        mem_addr   <= addr_a;
        mem_wdata  <= wdata_a;
        mem_we     <= we_a;
        r_last_b   <= 1'b0;
        lock_owner <= lock_a ? OWN_A : OWN_NONE;
      end else if (w_win_b) begin
        mem_addr   <= addr_b;
        mem_wdata  <= wdata_b;
        mem_we     <= we_b;
        r_last_b   <= 1'b1;
        lock_owner <= lock_b ? OWN_B : OWN_NONE;
      end else if (w_timeout) begin
        lock_owner  <= OWN_NONE;
        timeout_err <= 1'b1;
        r_last_b    <= (lock_owner == OWN_B);
      end

      if (w_win_a | w_win_b | w_timeout | (lock_owner == OWN_NONE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_p1_v <= (w_win_a & ~we_a) | (w_win_b & ~we_b);
      r_p1_b <= w_win_b;
      r_p2_v <= r_p1_v;
      r_p2_b <= r_p1_b;

      if (r_p2_v) begin
        if (r_p2_b) begin
          rvalid_b <= 1'b1;
          rdata_b  <= mem_rdata;
        end else begin
          rvalid_a <= 1'b1;
          rdata_a  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_reg_arbiter.sv
// tb_sd_reg_arbiter
//   Directed scenarios followed by randomized traffic on both requesters
//   (including random resets), checked every cycle against a
//   transaction-level reference model of the arbiter and register file.
module tb_sd_reg_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int LT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, we_a, lock_a, req_b, we_b, lock_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    lock_owner;
  logic          timeout_err;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  sd_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)) u_dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lock_owner(lock_owner), .timeout_err(timeout_err)
  );

  // Register file: synchronous write, 1-cycle read; contents set on first edge
  logic [DW-1:0] regs [128];
  bit            regs_init = 1'b0;
  always @(posedge clk) begin
    if (!regs_init) begin
      for (int i = 0; i < 128; i++) regs[i] <= 8'(i) ^ 8'h48;
      regs_init <= 1'b1;
    end else begin
      if (mem_we) regs[mem_addr] <= mem_wdata;
      mem_rdata <= regs[mem_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int       due;
    bit       port_b;
    bit [7:0] data;
  } rd_t;

  rd_t      rdq[$];
  bit [7:0] mmem [128];
  int       cyc = 0;
  int       owner = 0;     // 0 none, 1 A, 2 B
  int       idle = 0;      // edges since owner's last accepted transaction
  bit       last_b = 1'b1;
  bit       ea, eb, wa, wb;
  bit       e_gnt_a = 0, e_gnt_b = 0, e_rvalid_a = 0, e_rvalid_b = 0;
  bit       e_mem_we = 0, e_terr = 0;
  bit [7:0] e_rdata_a = 0, e_rdata_b = 0, e_mem_wdata = 0;
  bit [6:0] e_mem_addr = 0;
  bit [1:0] e_owner = 0;
  rd_t      rd;

  always @(posedge clk) begin
    cyc++;
    if (cyc == 1) for (int i = 0; i < 128; i++) mmem[i] = 8'(i) ^ 8'h48;
    if (rst) begin
      e_gnt_a = 0; e_gnt_b = 0; e_rvalid_a = 0; e_rvalid_b = 0;
      e_rdata_a = 0; e_rdata_b = 0; e_mem_addr = 0; e_mem_we = 0;
      e_mem_wdata = 0; e_terr = 0; e_owner = 0;
      rdq.delete();
      owner = 0; idle = 0; last_b = 1'b1;
    end else begin
      ea = req_a && !e_gnt_a && owner != 2;
      eb = req_b && !e_gnt_b && owner != 1;
      if (ea && eb) begin wa = last_b; wb = !last_b; end
      else begin wa = ea; wb = eb; end
      e_gnt_a = wa; e_gnt_b = wb;
      e_mem_we = 0; e_terr = 0; e_rvalid_a = 0; e_rvalid_b = 0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        rd = rdq.pop_front();
        if (rd.port_b) begin e_rvalid_b = 1; e_rdata_b = rd.data; end
        else begin e_rvalid_a = 1; e_rdata_a = rd.data; end
      end
      if (wa || wb) begin
        e_mem_addr  = wa ? addr_a : addr_b;
        e_mem_wdata = wa ? wdata_a : wdata_b;
        e_mem_we    = wa ? we_a : we_b;
        if (e_mem_we) mmem[e_mem_addr] = e_mem_wdata;
        else rdq.push_back('{cyc + 2, wb, mmem[e_mem_addr]});
        last_b = wb;
        owner  = (wa ? lock_a : lock_b) ? (wa ? 1 : 2) : 0;
        idle   = 0;
      end else if (owner != 0) begin
        idle++;
        if (idle == LT) begin
          e_terr = 1; last_b = (owner == 2); owner = 0; idle = 0;
        end
      end
      e_owner = 2'(owner);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("gnt_a", 32'(gnt_a), 32'(e_gnt_a));
    chk("gnt_b", 32'(gnt_b), 32'(e_gnt_b));
    chk("rvalid_a", 32'(rvalid_a), 32'(e_rvalid_a));
    chk("rvalid_b", 32'(rvalid_b), 32'(e_rvalid_b));
    chk("rdata_a", 32'(rdata_a), 32'(e_rdata_a));
    chk("rdata_b", 32'(rdata_b), 32'(e_rdata_b));
    chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
    chk("mem_we", 32'(mem_we), 32'(e_mem_we));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
    chk("lock_owner", 32'(lock_owner), 32'(e_owner));
    chk("timeout_err", 32'(timeout_err), 32'(e_terr));
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  // Issue one transaction on a port and return in its gnt cycle, req dropped
  task automatic txn(input bit pb, input bit we, input bit lk,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    if (pb) begin req_b = 1; we_b = we; lock_b = lk; addr_b = a; wdata_b = d; end
    else begin req_a = 1; we_a = we; lock_a = lk; addr_a = a; wdata_a = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = pb ? gnt_b : gnt_a;
    end
    chk(pb ? "gnt_b_wait" : "gnt_a_wait", 32'(got), 32'd1);
    if (pb) req_b = 0; else req_a = 0;
  endtask

  task automatic drive_req(input bit granted, inout logic req, inout logic we,
                           inout logic lk, inout logic [AW-1:0] addr,
                           inout logic [DW-1:0] wd, inout int gap);
    if (req && granted) begin
      req = 0;
      gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1));
    end
    if (!req) begin
      if (gap > 0) gap--;
      else begin
        req  = 1;
        we   = 1'($urandom_range(0, 1));
        lk   = ($urandom_range(0, 3) == 0);
        addr = 7'($urandom_range(0, 7));
        wd   = 8'($urandom);
      end
    end
  endtask

  int gap_a = 0, gap_b = 0;

  initial begin
    rst = 1; req_a = 0; we_a = 0; lock_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; lock_b = 0; addr_b = '0; wdata_b = '0;
    repeat (3) step();
    rst = 0;
    step();

    // single read of 0x12 (0x5A)
    txn(0, 0, 0, 7'h12, 8'h00);
    repeat (4) step();

    // tie and round robin: A reads 0x05, B writes 0xC3 to 0x05
    req_a = 1; we_a = 0; lock_a = 0; addr_a = 7'h05;
    req_b = 1; we_b = 1; lock_b = 0; addr_b = 7'h05; wdata_b = 8'hC3;
    repeat (8) step();
    req_a = 0; req_b = 0;
    repeat (4) step();

    // lock sequence with B requesting throughout
    req_b = 1; we_b = 1; lock_b = 0; addr_b = 7'h06; wdata_b = 8'h99;
    txn(0, 1, 1, 7'h01, 8'h11);
    txn(0, 1, 1, 7'h02, 8'h22);
    txn(0, 1, 0, 7'h03, 8'h33);
    repeat (3) step();
    req_b = 0;
    repeat (3) step();

    // timeout: A locks then goes quiet while B waits
    req_b = 1; we_b = 0; lock_b = 0; addr_b = 7'h01;
    txn(0, 1, 1, 7'h20, 8'h44);
    repeat (LT + 4) step();
    req_b = 0;
    repeat (4) step();

    // read-after-write across ports
    txn(1, 1, 0, 7'h40, 8'h7E);
    txn(0, 0, 0, 7'h40, 8'h00);
    repeat (4) step();

    // reset during a read in flight, then a tie
    txn(0, 0, 0, 7'h12, 8'h00);
    step();
    rst = 1;
    step();
    rst = 0;
    req_a = 1; we_a = 0; lock_a = 0; addr_a = 7'h03;
    req_b = 1; we_b = 0; lock_b = 0; addr_b = 7'h04;
    repeat (5) step();
    req_a = 0; req_b = 0;
    repeat (4) step();

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      step();
      drive_req(gnt_a, req_a, we_a, lock_a, addr_a, wdata_a, gap_a);
      drive_req(gnt_b, req_b, we_b, lock_b, addr_b, wdata_b, gap_b);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 0; req_a = 0; req_b = 0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
